// File: rtl/alu181_nibble_sequencer.sv
// rtl/alu181_nibble_sequencer.sv - drives one 74181 nibble by nibble, LSB first, rippling carry in a register.
// Optional ALU181_EQ_EN: aggregates the ALU A=B output across all nibbles into eq.
module alu181_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
    input  logic [3:0]             op_s,
    input  logic                   op_m,
    input  logic                   cin,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   result,
    output logic                   cout,
    output logic                   eq,
    output logic [3:0]             alu_a_n,
    output logic [3:0]             alu_b_n,
    output logic [3:0]             alu_s,
    output logic                   alu_m,
    output logic                   alu_cn,
    input  logic [3:0]             alu_f_n,
    input  logic                   alu_cn4,
    input  logic                   alu_aeqb
);
    localparam int WIDTH = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, SAMPLE, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [3:0]       s_lat;
    logic             m_lat;
    logic             carry;
    logic             last_nibble;
    logic [KW+1:0]    bit_base;

    assign last_nibble = (k == K_LAST);
    assign bit_base    = {k, 2'b00};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   state_nxt = SAMPLE;
            SAMPLE:  state_nxt = last_nibble ? DONE : ISSUE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ALU181_EQ_EN
    logic eq_acc;
`else
    logic unused_aeqb;
    assign unused_aeqb = alu_aeqb;
    assign eq          = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            alu_a_n <= 4'hF;
            alu_b_n <= 4'hF;
            alu_s   <= 4'h0;
            alu_m   <= 1'b1;
            alu_cn  <= 1'b0;
            k       <= '0;
            a_lat   <= '0;
            b_lat   <= '0;
            s_lat   <= 4'h0;
            m_lat   <= 1'b1;
            carry   <= 1'b0;
`ifdef ALU181_EQ_EN
            eq_acc  <= 1'b0;
            eq      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_lat  <= a;
                        b_lat  <= b;
                        s_lat  <= op_s;
                        m_lat  <= op_m;
                        carry  <= cin;
                        k      <= '0;
                        busy   <= 1'b1;
                        // Old result is cleared so only nibbles of this operation are ever visible.
                        result <= '0;
`ifdef ALU181_EQ_EN
                        eq_acc <= 1'b1;
`endif
                    end
                end
                ISSUE: begin
                    alu_a_n <= ~a_lat[bit_base +: 4];
                    alu_b_n <= ~b_lat[bit_base +: 4];
                    alu_s   <= s_lat;
                    alu_m   <= m_lat;
                    alu_cn  <= carry;
                end
                SAMPLE: begin
                    result[bit_base +: 4] <= ~alu_f_n;
                    carry <= alu_cn4;
`ifdef ALU181_EQ_EN
                    eq_acc <= eq_acc & alu_aeqb;
`endif
                    if (last_nibble) begin
                        k    <= '0;
                        done <= 1'b1;
                        busy <= 1'b0;
                        // In logic mode the ALU still produces a carry, but it carries no meaning.
                        cout <= m_lat ? 1'b0 : alu_cn4;
`ifdef ALU181_EQ_EN
                        eq   <= eq_acc & alu_aeqb;
`endif
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu181_nibble_sequencer.sv
// tb/tb_alu181_nibble_sequencer.sv - self-checking bench with a behavioural 74181 and an operation-level model.
module tb_alu181_nibble_sequencer;
    localparam int N        = 4;
    localparam int CYC_DONE = 2 * N + 1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op_s = 4'h0;
    logic        op_m = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, cout, eq;
    logic [15:0] result;
    logic [3:0]  alu_a_n, alu_b_n, alu_s, alu_f_n;
    logic        alu_m, alu_cn, alu_cn4, alu_aeqb;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    alu181_nibble_sequencer #(.NIBBLES(N)) dut (
        .CLK(CLK), .RST(RST), .start(start), .op_s(op_s), .op_m(op_m), .cin(cin),
        .a(a), .b(b), .busy(busy), .done(done), .result(result), .cout(cout), .eq(eq),
        .alu_a_n(alu_a_n), .alu_b_n(alu_b_n), .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn),
        .alu_f_n(alu_f_n), .alu_cn4(alu_cn4), .alu_aeqb(alu_aeqb)
    );

    // 74181 at pin level, active-high-data view: Cn and Cn+4 low mean carry.
    logic [3:0] t1, t2;
    logic [4:0] chip_sum;
    always_comb begin
        t1       = alu_a_n | (alu_b_n & {4{alu_s[0]}}) | (~alu_b_n & {4{alu_s[1]}});
        t2       = (alu_a_n & ~alu_b_n & {4{alu_s[2]}}) | (alu_a_n & alu_b_n & {4{alu_s[3]}});
        chip_sum = {1'b0, t1} + {1'b0, t2} + {4'b0, ~alu_cn};
        alu_f_n  = alu_m ? ~(t1 ^ t2) : chip_sum[3:0];
        alu_cn4  = ~chip_sum[4];
        alu_aeqb = (alu_f_n == 4'hF);
    end

    // Whole-word expectation: {eq, cout, result}.
    function automatic logic [17:0] expect_op(input logic [3:0] s, input logic m, input logic c,
                                              input logic [15:0] x, input logic [15:0] y);
        logic [16:0] sum;
        logic [15:0] r;
        logic        co;
        logic        e;
        if (m) begin
            r  = x ^ y;
            co = 1'b0;
        end else begin
            if (s == 4'b0110) sum = {1'b0, x} + {1'b0, ~y} + {16'b0, c};
            else              sum = {1'b0, x} + {1'b0, y} + {16'b0, c};
            r  = sum[15:0];
            co = sum[16];
        end
`ifdef ALU181_EQ_EN
        e = (r == 16'h0);
`else
        e = 1'b0;
`endif
        return {e, co, r};
    endfunction

    int          m_cnt = 0;
    logic [15:0] m_res = '0;
    logic        m_cout = 1'b0;
    logic        m_eq = 1'b0;
    logic [17:0] m_pend = '0;

    always @(posedge CLK) begin
        if (RST) begin
            m_cnt = 0; m_res = '0; m_cout = 1'b0; m_eq = 1'b0;
        end else if (m_cnt == CYC_DONE) begin
            m_cnt = 0;
        end else if (m_cnt > 0) begin
            m_cnt++;
            if (m_cnt == CYC_DONE) {m_eq, m_cout, m_res} = m_pend;
        end else if (start) begin
            m_pend = expect_op(op_s, op_m, cin, a, b);
            m_cnt  = 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        check("busy", {31'b0, busy}, {31'b0, (m_cnt >= 1 && m_cnt < CYC_DONE)});
        check("done", {31'b0, done}, {31'b0, (m_cnt == CYC_DONE)});
        if (m_cnt == 0 || m_cnt == CYC_DONE) begin
            check("result", {16'b0, result}, {16'b0, m_res});
            check("cout", {31'b0, cout}, {31'b0, m_cout});
            check("eq", {31'b0, eq}, {31'b0, m_eq});
        end
    end

    // Start is re-pulsed with junk operands while busy; the model ignores those.
    task automatic run_op(input logic [3:0] s, input logic m, input logic c,
                          input logic [15:0] av, input logic [15:0] bv,
                          output logic [15:0] r, output logic co, output logic e, output int lat);
        @(posedge CLK); #1;
        op_s = s; op_m = m; cin = c; a = av; b = bv; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        lat = 0;
        for (int i = 1; i < 30; i++) begin
            @(negedge CLK);
            if (done) begin
                lat = i;
                break;
            end
            start = 1'($urandom_range(0, 1));
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        r = result; co = cout; e = eq;
    endtask

    logic [15:0] r;
    logic        co, e, exp_eq1;
    int          lat;
    int          done_seen;

    initial begin
`ifdef ALU181_EQ_EN
        exp_eq1 = 1'b1;
`else
        exp_eq1 = 1'b0;
`endif
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_alu_a_n", {28'b0, alu_a_n}, 32'hF);
        check("rst_alu_b_n", {28'b0, alu_b_n}, 32'hF);
        check("rst_alu_s", {28'b0, alu_s}, 32'h0);
        check("rst_alu_m", {31'b0, alu_m}, 32'h1);
        check("rst_alu_cn", {31'b0, alu_cn}, 32'h0);
        @(posedge CLK); #1 RST = 1'b0;

        run_op(4'b1001, 1'b0, 1'b0, 16'h1234, 16'h0FFF, r, co, e, lat);
        check("add1_result", {16'b0, r}, 32'h2233);
        check("add1_cout", {31'b0, co}, 32'h0);
        check("add1_latency", lat, 32'd9);

        run_op(4'b1001, 1'b0, 1'b0, 16'hFFFF, 16'h0001, r, co, e, lat);
        check("add2_result", {16'b0, r}, 32'h0000);
        check("add2_cout", {31'b0, co}, 32'h1);
        check("add2_latency", lat, 32'd9);

        run_op(4'b0110, 1'b0, 1'b1, 16'h0005, 16'h0007, r, co, e, lat);
        check("sub1_result", {16'b0, r}, 32'hFFFE);
        check("sub1_cout", {31'b0, co}, 32'h0);

        run_op(4'b0110, 1'b0, 1'b1, 16'h0007, 16'h0005, r, co, e, lat);
        check("sub2_result", {16'b0, r}, 32'h0002);
        check("sub2_cout", {31'b0, co}, 32'h1);

        run_op(4'b1001, 1'b1, 1'b1, 16'hF0F0, 16'hFF00, r, co, e, lat);
        check("xor_result", {16'b0, r}, 32'h0FF0);
        check("xor_cout", {31'b0, co}, 32'h0);

        run_op(4'b0110, 1'b0, 1'b1, 16'h5A5A, 16'h5A5A, r, co, e, lat);
        check("eq1_result", {16'b0, r}, 32'h0000);
        check("eq1_eq", {31'b0, e}, {31'b0, exp_eq1});

        run_op(4'b0110, 1'b0, 1'b1, 16'h5A5B, 16'h5A5A, r, co, e, lat);
        check("eq0_result", {16'b0, r}, 32'h0001);
        check("eq0_eq", {31'b0, e}, 32'h0);

        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 2))
                0:       run_op(4'b1001, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), r, co, e, lat);
                1:       run_op(4'b0110, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), r, co, e, lat);
                default: run_op(4'b1001, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), r, co, e, lat);
            endcase
            check("rand_latency", lat, 32'd9);
        end

        // Abort: second start while busy, then reset during the second SAMPLE cycle.
        @(posedge CLK); #1;
        op_s = 4'b1001; op_m = 1'b0; cin = 1'b0; a = 16'h1111; b = 16'h2222; start = 1'b1;
        @(posedge CLK); #1 start = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1 start = 1'b1; a = 16'h7777;
        @(posedge CLK); #1 start = 1'b0; RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_result", {16'b0, result}, 32'h0);
        check("abort_alu_a_n", {28'b0, alu_a_n}, 32'hF);
        check("abort_alu_m", {31'b0, alu_m}, 32'h1);
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge CLK);
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
